// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: one WIDTH/STAGES-bit slice is added per
// stage, with the slice carry registered between stages and valid/ready flow control.
module pipe_addsub #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int SW   = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             c_msb;
   logic             advance;
   logic             c0;
   logic [WIDTH-1:0] b_pre;

   // Handshake: a transfer happens on an edge where valid && ready. The whole
   // pipe moves together whenever the output slot is empty or being drained.
   always_comb begin
      advance = out_ready || !out_valid_q;
      b_pre   = sub ? ~b : b;
      c0      = sub ? 1'b1 : cin;
   end

   assign in_ready = advance;

   for (genvar k = 0; k < STAGES; k++) begin : stg
      localparam int IW = WIDTH - k * SW;

      logic             v_in;
      logic             c_in;
      logic [WIDTH-1:0] word_in;
      logic [WIDTH-1:0] word_out;
      logic [IW-1:0]    b_in;
      logic [SW:0]      add;

      // word holds the not-yet-added A slices in its low part and the finished
      // sum slices in its high part; each stage rotates right by one slice.
      if (k == 0) begin : g_head
         always_comb begin
            v_in    = in_valid;
            word_in = a;
            b_in    = b_pre;
            c_in    = c0;
         end
      end else begin : g_reg
         logic             v_d, v_q;
         logic             c_d, c_q;
         logic [WIDTH-1:0] word_d, word_q;
         logic [IW-1:0]    b_d, b_q;

         always_comb begin
            v_d    = stg[k-1].v_in;
            c_d    = stg[k-1].add[SW];
            word_d = stg[k-1].word_out;
            b_d    = stg[k-1].b_in[IW+SW-1:SW];
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               v_q    <= 1'b0;
               c_q    <= 1'b0;
               word_q <= '0;
               b_q    <= '0;
            end else if (advance) begin
               v_q    <= v_d;
               c_q    <= c_d;
               word_q <= word_d;
               b_q    <= b_d;
            end
         end

         always_comb begin
            v_in    = v_q;
            word_in = word_q;
            b_in    = b_q;
            c_in    = c_q;
         end
      end

      always_comb begin
         add = {1'b0, word_in[SW-1:0]} + {1'b0, b_in[SW-1:0]} + {{SW{1'b0}}, c_in};
      end

      if (SW == WIDTH) begin : g_whole
         assign word_out = add[SW-1:0];
      end else begin : g_rot
         assign word_out = {add[SW-1:0], word_in[WIDTH-1:SW]};
      end
   end

   // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
   always_comb begin
      out_valid_d = stg[LAST].v_in;
      sum_d       = stg[LAST].word_out;
      cout_d      = stg[LAST].add[SW];
      c_msb       = stg[LAST].add[SW-1] ^ stg[LAST].word_in[SW-1] ^ stg[LAST].b_in[SW-1];
      ovf_d       = c_msb ^ cout_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else if (advance) begin
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub: directed and random operands against an integer
// arithmetic reference model, for a 16-bit/4-stage and an 8-bit/1-stage instance.
module tb_pipe_addsub;
   localparam int W  = 16;
   localparam int S  = 4;
   localparam int W8 = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
   logic [W-1:0]  a, b, sum;
   logic          in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8;
   logic [W8-1:0] a8, b8, sum8;

   int            checks = 0;
   int            errors = 0;
   int            edge_n = 0;
   // {ovf, cout, sum[15:0]}
   logic [17:0]   exp_q[$];

   always #5 clk = ~clk;

   pipe_addsub #(.WIDTH(W), .STAGES(S)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
   );

   pipe_addsub #(.WIDTH(W8), .STAGES(1)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid8),
      .out_ready(out_ready8), .sum(sum8), .cout(cout8), .ovf(ovf8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the unsigned and signed readings.
   function automatic logic [17:0] model(input int w, input longint ua, input longint ub,
                                         input bit c, input bit s);
      longint      m;
      longint      cl;
      longint      r, sa, sb, sr;
      logic [17:0] res;
      m  = longint'(1) << w;
      cl = longint'(c);
      r  = s ? ua - ub : ua + ub + cl;
      res = '0;
      res[15:0] = 16'(((r % m) + m) % m);
      res[16]   = s ? (ua >= ub) : (r >= m);
      sa = (ua >= m / 2) ? ua - m : ua;
      sb = (ub >= m / 2) ? ub - m : ub;
      sr = s ? sa - sb : sa + sb + cl;
      res[17] = (sr < -(m / 2)) || (sr >= m / 2);
      return res;
   endfunction

   // One clock: sample just after the falling edge, score outputs, record accepts.
   task automatic cycle(output bit acc);
      logic [17:0] e;
      #1;
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("spurious_out", 32'(out_valid), 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("sb_sum", 32'(sum), 32'(e[15:0]));
            chk("sb_cout", 32'(cout), 32'(e[16]));
            chk("sb_ovf", 32'(ovf), 32'(e[17]));
         end
      end
      if (acc) exp_q.push_back(model(W, longint'(a), longint'(b), cin, sub));
      @(posedge clk);
      edge_n++;
      @(negedge clk);
   endtask

   task automatic send_directed(input string tag, input logic [15:0] av, input logic [15:0] bv,
                                input bit cv, input bit sv, input logic [15:0] es,
                                input bit ec, input bit eo);
      bit acc;
      int lat;
      a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1; out_ready = 1'b1;
      cycle(acc);
      chk({tag, "_accept"}, 32'(acc), 32'd1);
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom);
      lat = 0;
      while (!out_valid && lat < 12) begin
         cycle(acc);
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'(S - 1));
      chk({tag, "_sum"}, 32'(sum), 32'(es));
      chk({tag, "_cout"}, 32'(cout), 32'(ec));
      chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
      cycle(acc);
   endtask

   task automatic test8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input bit cv, input bit sv, input logic [7:0] es,
                        input bit ec, input bit eo);
      logic [17:0] e;
      e = model(W8, longint'(av), longint'(bv), cv, sv);
      a8 = av; b8 = bv; cin8 = cv; sub8 = sv; in_valid8 = 1'b1; out_ready8 = 1'b1;
      #1;
      chk({tag, "_in_ready"}, 32'(in_ready8), 32'd1);
      chk({tag, "_pre_valid"}, 32'(out_valid8), 32'd0);
      @(posedge clk);
      @(negedge clk);
      in_valid8 = 1'b0;
      chk({tag, "_valid"}, 32'(out_valid8), 32'd1);
      chk({tag, "_sum"}, 32'(sum8), 32'(es));
      chk({tag, "_cout"}, 32'(cout8), 32'(ec));
      chk({tag, "_ovf"}, 32'(ovf8), 32'(eo));
      chk({tag, "_model"}, 32'({ovf8, cout8, sum8}), 32'({e[17], e[16], e[7:0]}));
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_drained"}, 32'(out_valid8), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      bit          acc;
      bit          need_new;
      int          i, cnt, first, last, acc_edge;
      logic [17:0] e;

      rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
      in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;

      // Clock/reset
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);

      // Directed arithmetic corners
      send_directed("carry_mid", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
      send_directed("carry_full", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
      send_directed("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      send_directed("sub_borrow", 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      send_directed("sub_cin_ignored", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);

      // Back-to-back throughput
      edge_n = 0; i = 0; cnt = 0; first = -1; last = -1; acc_edge = -1;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 40 && (i < 8 || exp_q.size() > 0); cyc++) begin
         if (i < 8) begin
            a = 16'($urandom_range(0, 16'hFFFF)); b = 16'($urandom_range(0, 16'hFFFF));
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         if (out_valid) begin
            if (first < 0) first = edge_n;
            last = edge_n;
            cnt++;
         end
         cycle(acc);
         if (acc) begin
            if (i == 0) acc_edge = edge_n - 1;
            i++;
         end
      end
      chk("b2b_count", 32'(cnt), 32'd8);
      chk("b2b_first", 32'(first), 32'(acc_edge + S));
      chk("b2b_contig", 32'(last - first), 32'd7);
      chk("b2b_drain", 32'(exp_q.size()), 32'd0);

      // Backpressure mid-stream
      i = 0; need_new = 1'b1;
      for (int cyc = 0; cyc < 40 && (i < 6 || exp_q.size() > 0); cyc++) begin
         out_ready = !(cyc >= 4 && cyc <= 6);
         if (i < 6) begin
            if (need_new) begin
               a = 16'($urandom_range(0, 16'hFFFF)); b = 16'($urandom_range(0, 16'hFFFF));
               cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
               need_new = 1'b0;
            end
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         if (!out_ready) begin
            #1;
            e = exp_q[0];
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_valid_held", 32'(out_valid), 32'd1);
            chk("bp_sum_held", 32'(sum), 32'(e[15:0]));
            chk("bp_cout_held", 32'(cout), 32'(e[16]));
            chk("bp_ovf_held", 32'(ovf), 32'(e[17]));
         end
         cycle(acc);
         if (acc) begin
            i++;
            need_new = 1'b1;
         end
      end
      out_ready = 1'b1;
      chk("bp_items", 32'(i), 32'd6);
      chk("bp_drain", 32'(exp_q.size()), 32'd0);

      // Reset with items in flight
      for (int k = 0; k < 4; k++) begin
         a = 16'($urandom_range(1, 16'hFFFF)); b = 16'($urandom_range(1, 16'hFFFF));
         cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
         cycle(acc);
      end
      in_valid = 1'b0;
      chk("mid_pre_valid", 32'(out_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_sum", 32'(sum), 32'd0);
      chk("mid_rst_cout", 32'(cout), 32'd0);
      chk("mid_rst_ovf", 32'(ovf), 32'd0);
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_rel_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      a = 16'($urandom_range(0, 16'hFFFF)); b = 16'($urandom_range(0, 16'hFFFF));
      e = model(W, longint'(a), longint'(b), 1'b0, 1'b1);
      send_directed("post_rst", a, b, 1'b0, 1'b1, e[15:0], e[16], e[17]);
      chk("post_rst_drain", 32'(exp_q.size()), 32'd0);

      // Single-stage 8-bit instance
      test8("s1_carry", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
      test8("s1_full", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      test8("s1_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
      test8("s1_sub", 8'h03, 8'h05, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
